// File: rtl/proto_host_initiator.sv
// Host-side initiator: sends (cmd, data) over a 4-phase req/ack byte link and
// collects 1 or 3 response bytes from the return 4-phase link into one word.
// Ports: in_clk/in_rst_n (async active-low); in_cmd_valid/in_cmd/in_data (start);
//   out_busy; out_link_tx/out_link_tx_hsk_req/in_link_tx_hsk_ack/in_peer_rx_enable (tx link);
//   in_link_rx/in_link_rx_hsk_req/out_link_rx_hsk_ack (rx link);
//   out_resp_valid/out_resp_data/out_resp_len/out_error (result).
// Option: define PROTO_HOST_TIMEOUT_EN to abort peer waits after TIMEOUT_CYCLES clocks.
module proto_host_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        in_clk,
   input  logic        in_rst_n,
   input  logic        in_cmd_valid,
   input  logic [7:0]  in_cmd,
   input  logic [7:0]  in_data,
   output logic        out_busy,
   output logic [7:0]  out_link_tx,
   output logic        out_link_tx_hsk_req,
   input  logic        in_link_tx_hsk_ack,
   input  logic        in_peer_rx_enable,
   input  logic [7:0]  in_link_rx,
   input  logic        in_link_rx_hsk_req,
   output logic        out_link_rx_hsk_ack,
   output logic        out_resp_valid,
   output logic [23:0] out_resp_data,
   output logic [1:0]  out_resp_len,
   output logic        out_error
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_TX_WAIT_EN  = 3'd1,
      S_TX_REQ      = 3'd2,
      S_TX_ACK_LOW  = 3'd3,
      S_RX_WAIT_REQ = 3'd4,
      S_RX_ACK      = 3'd5,
      S_DONE        = 3'd6
   } state_t;

   state_t     state;
   logic [7:0] data_q;
   logic [1:0] byte_idx;
   logic [1:0] expect_len;
   logic [1:0] rx_count;
   logic       timeout_hit;

   // In RX_ACK the current byte is already stored, so it counts as received.
   assign rx_count = (state == S_RX_ACK)      ? byte_idx + 2'd1 :
                     (state == S_RX_WAIT_REQ) ? byte_idx : 2'd0;

`ifdef PROTO_HOST_TIMEOUT_EN
   logic [15:0] to_cnt;
   state_t      st_prev;
   logic        counting;

   assign counting = state inside {S_TX_WAIT_EN, S_TX_REQ, S_TX_ACK_LOW,
                                   S_RX_WAIT_REQ, S_RX_ACK};

   // to_cnt holds the number of clocks already spent in the current state;
   // a state change restarts it.
   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         to_cnt  <= '0;
         st_prev <= S_IDLE;
      end else begin
         st_prev <= state;
         if (!counting)
            to_cnt <= '0;
         else if (state != st_prev)
            to_cnt <= 16'd1;
         else
            to_cnt <= to_cnt + 16'd1;
      end
   end

   assign timeout_hit = counting && (state == st_prev) &&
                        (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state               <= S_IDLE;
         data_q              <= '0;
         byte_idx            <= '0;
         expect_len          <= '0;
         out_busy            <= 1'b0;
         out_link_tx         <= '0;
         out_link_tx_hsk_req <= 1'b0;
         out_link_rx_hsk_ack <= 1'b0;
         out_resp_valid      <= 1'b0;
         out_resp_data       <= '0;
         out_resp_len        <= '0;
         out_error           <= 1'b0;
      end else begin
         out_resp_valid <= 1'b0;
         if (timeout_hit) begin
            state               <= S_IDLE;
            byte_idx            <= '0;
            out_busy            <= 1'b0;
            out_link_tx_hsk_req <= 1'b0;
            out_link_rx_hsk_ack <= 1'b0;
            out_resp_valid      <= 1'b1;
            out_resp_len        <= rx_count;
            out_error           <= 1'b1;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (in_cmd_valid) begin
                     data_q        <= in_data;
                     out_link_tx   <= in_cmd;
                     byte_idx      <= '0;
                     expect_len    <= (in_cmd == 8'h00 || in_cmd == 8'h01) ? 2'd1 : 2'd3;
                     out_resp_data <= '0;
                     out_resp_len  <= '0;
                     out_error     <= 1'b0;
                     out_busy      <= 1'b1;
                     state         <= S_TX_WAIT_EN;
                  end
               end
               S_TX_WAIT_EN: begin
                  if (in_peer_rx_enable) begin
                     out_link_tx_hsk_req <= 1'b1;
                     state               <= S_TX_REQ;
                  end
               end
               S_TX_REQ: begin
                  if (in_link_tx_hsk_ack) begin
                     out_link_tx_hsk_req <= 1'b0;
                     state               <= S_TX_ACK_LOW;
                  end
               end
               S_TX_ACK_LOW: begin
                  if (!in_link_tx_hsk_ack) begin
                     if (byte_idx == 2'd0) begin
                        byte_idx    <= 2'd1;
                        out_link_tx <= data_q;
                        state       <= S_TX_WAIT_EN;
                     end else begin
                        byte_idx <= 2'd0;
                        state    <= S_RX_WAIT_REQ;
                     end
                  end
               end
               S_RX_WAIT_REQ: begin
                  if (in_link_rx_hsk_req) begin
                     case (byte_idx)
                        2'd0:    out_resp_data[7:0]   <= in_link_rx;
                        2'd1:    out_resp_data[15:8]  <= in_link_rx;
                        default: out_resp_data[23:16] <= in_link_rx;
                     endcase
                     out_link_rx_hsk_ack <= 1'b1;
                     state               <= S_RX_ACK;
                  end
               end
               S_RX_ACK: begin
                  if (!in_link_rx_hsk_req) begin
                     out_link_rx_hsk_ack <= 1'b0;
                     byte_idx            <= byte_idx + 2'd1;
                     if (byte_idx + 2'd1 == expect_len) begin
                        out_resp_valid <= 1'b1;
                        out_resp_len   <= expect_len;
                        out_error      <= 1'b0;
                        state          <= S_DONE;
                     end else begin
                        state <= S_RX_WAIT_REQ;
                     end
                  end
               end
               S_DONE: begin
                  out_busy <= 1'b0;
                  state    <= S_IDLE;
               end
               default: begin
                  out_busy            <= 1'b0;
                  out_link_tx_hsk_req <= 1'b0;
                  out_link_rx_hsk_ack <= 1'b0;
                  state               <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_proto_host_initiator.sv
// Bench for proto_host_initiator: directed transactions against a bench-side
// peer and a transaction-level model of the expected response.
module tb_proto_host_initiator;

   logic        in_clk = 1'b0;
   logic        in_rst_n = 1'b0;
   logic        in_cmd_valid = 1'b0;
   logic [7:0]  in_cmd = '0;
   logic [7:0]  in_data = '0;
   logic        out_busy;
   logic [7:0]  out_link_tx;
   logic        out_link_tx_hsk_req;
   logic        in_link_tx_hsk_ack = 1'b0;
   logic        in_peer_rx_enable = 1'b0;
   logic [7:0]  in_link_rx = '0;
   logic        in_link_rx_hsk_req = 1'b0;
   logic        out_link_rx_hsk_ack;
   logic        out_resp_valid;
   logic [23:0] out_resp_data;
   logic [1:0]  out_resp_len;
   logic        out_error;

   proto_host_initiator #(.TIMEOUT_CYCLES(16)) dut (
      .in_clk              (in_clk),
      .in_rst_n            (in_rst_n),
      .in_cmd_valid        (in_cmd_valid),
      .in_cmd              (in_cmd),
      .in_data             (in_data),
      .out_busy            (out_busy),
      .out_link_tx         (out_link_tx),
      .out_link_tx_hsk_req (out_link_tx_hsk_req),
      .in_link_tx_hsk_ack  (in_link_tx_hsk_ack),
      .in_peer_rx_enable   (in_peer_rx_enable),
      .in_link_rx          (in_link_rx),
      .in_link_rx_hsk_req  (in_link_rx_hsk_req),
      .out_link_rx_hsk_ack (out_link_rx_hsk_ack),
      .out_resp_valid      (out_resp_valid),
      .out_resp_data       (out_resp_data),
      .out_resp_len        (out_resp_len),
      .out_error           (out_error)
   );

   always #5 in_clk = ~in_clk;

   int n_tests = 0;
   int n_fail = 0;
   int rv_pulses = 0;
   int req_rises = 0;

   logic [23:0] exp_data = '0;
   logic [1:0]  exp_len = '0;
   logic        exp_err = 1'b0;

   logic       mon_req_q = 1'b0;
   logic       mon_rv_q = 1'b0;
   logic [7:0] mon_tx_q = '0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endfunction

   function automatic logic pick(int w);
      case (w)
         0:       return out_link_tx_hsk_req;
         1:       return out_link_rx_hsk_ack;
         2:       return out_busy;
         default: return out_resp_valid;
      endcase
   endfunction

   task automatic wait_for(input int w, input logic v, input string nm);
      for (int i = 0; i < 300; i++) begin
         @(negedge in_clk);
         if (pick(w) === v) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL %s: wait bound expired, got %0b, want %0b", nm, pick(w), v);
   endtask

   // Every-cycle checker: link protocol rules and response against the model.
   initial begin
      forever begin
         @(negedge in_clk);
         if (!in_rst_n) begin
            mon_req_q = 1'b0;
            mon_rv_q  = 1'b0;
         end else begin
            chk("req_ack_excl", 32'(out_link_tx_hsk_req & out_link_rx_hsk_ack), 32'd0);
            if (out_link_tx_hsk_req && !mon_req_q) begin
               req_rises++;
               chk("req_rise_ack_low", 32'(in_link_tx_hsk_ack), 32'd0);
            end
            if (out_link_tx_hsk_req && mon_req_q)
               chk("tx_stable", 32'(out_link_tx), 32'(mon_tx_q));
            if (out_resp_valid) begin
               if (!mon_rv_q) rv_pulses++;
               chk("rv_width", 32'(mon_rv_q), 32'd0);
               chk("resp_len", 32'(out_resp_len), 32'(exp_len));
               chk("resp_data", 32'(out_resp_data), 32'(exp_data));
               chk("resp_err", 32'(out_error), 32'(exp_err));
            end
            mon_req_q = out_link_tx_hsk_req;
            mon_rv_q  = out_resp_valid;
            mon_tx_q  = out_link_tx;
         end
      end
   end

   task automatic peer_take_byte(input int en_delay, input int ack_hold,
                                 input logic [7:0] want, input string nm);
      repeat (en_delay) @(posedge in_clk);
      #1 in_peer_rx_enable = 1'b1;
      wait_for(0, 1'b1, {nm, "_req"});
      chk(nm, 32'(out_link_tx), 32'(want));
      @(posedge in_clk);
      #1 in_link_tx_hsk_ack = 1'b1;
      in_peer_rx_enable = 1'b0;
      wait_for(0, 1'b0, {nm, "_req_fall"});
      repeat (ack_hold) @(posedge in_clk);
      #1 in_link_tx_hsk_ack = 1'b0;
   endtask

   task automatic peer_give_byte(input logic [7:0] b, input string nm);
      @(posedge in_clk);
      #1 in_link_rx = b;
      in_link_rx_hsk_req = 1'b1;
      wait_for(1, 1'b1, {nm, "_ack"});
      @(posedge in_clk);
      #1 in_link_rx_hsk_req = 1'b0;
      wait_for(1, 1'b0, {nm, "_ack_fall"});
   endtask

   task automatic run_txn(input logic [7:0] c, input logic [7:0] d,
                          input logic [7:0] r0, input logic [7:0] r1,
                          input logic [7:0] r2, input int en2_delay,
                          input int ack_hold, input bit poke);
      int rv0;
      int rr0;
      int n;
      logic [7:0] b;
      n = (c == 8'h00 || c == 8'h01) ? 1 : 3;
      exp_len  = 2'(n);
      exp_err  = 1'b0;
      exp_data = (n == 1) ? {16'h0000, r0} : {r2, r1, r0};
      rv0 = rv_pulses;
      rr0 = req_rises;
      @(posedge in_clk);
      #1 in_cmd = c;
      in_data = d;
      in_cmd_valid = 1'b1;
      @(posedge in_clk);
      #1 in_cmd_valid = 1'b0;
      in_cmd = 8'hEE;
      in_data = 8'hEE;
      chk("busy_after_accept", 32'(out_busy), 32'd1);
      peer_take_byte(0, ack_hold, c, "tx_byte0");
      if (poke) begin
         in_cmd = 8'h01;
         in_cmd_valid = 1'b1;
         @(posedge in_clk);
         #1 in_cmd_valid = 1'b0;
      end
      peer_take_byte(en2_delay, ack_hold, d, "tx_byte1");
      for (int i = 0; i < n; i++) begin
         case (i)
            0:       b = r0;
            1:       b = r1;
            default: b = r2;
         endcase
         peer_give_byte(b, "rx_byte");
      end
      wait_for(2, 1'b0, "busy_fall");
      repeat (4) @(negedge in_clk);
      chk("rv_count", 32'(rv_pulses - rv0), 32'd1);
      chk("req_rises", 32'(req_rises - rr0), 32'd2);
      chk("idle_busy", 32'(out_busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rv0;
      repeat (3) @(posedge in_clk);
      @(negedge in_clk);
      chk("rst_ctrl", 32'({out_busy, out_link_tx_hsk_req, out_link_rx_hsk_ack,
                           out_resp_valid, out_error, out_resp_len}), 32'd0);
      chk("rst_data", 32'(out_resp_data), 32'd0);
      chk("rst_tx", 32'(out_link_tx), 32'd0);
      in_rst_n = 1'b1;

      // Stray peer request while idle must not be acknowledged.
      @(posedge in_clk);
      #1 in_link_rx_hsk_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge in_clk);
         chk("stray_req_no_ack", 32'({out_link_rx_hsk_ack, out_busy}), 32'd0);
      end
      in_link_rx_hsk_req = 1'b0;

      // T1
      run_txn(8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 0, 0, 1'b0);
      chk("t1_len", 32'(out_resp_len), 32'd1);
      chk("t1_data", 32'(out_resp_data), 32'h000000);
      // T2
      run_txn(8'h01, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, 0, 1'b0);
      chk("t2_byte0", 32'(out_resp_data[7:0]), 32'hA5);
      chk("t2_err", 32'(out_error), 32'd0);
      // T3
      run_txn(8'h10, 8'h05, 8'h15, 8'h02, 8'h01, 0, 0, 1'b0);
      chk("t3_len", 32'(out_resp_len), 32'd3);
      chk("t3_data", 32'(out_resp_data), 32'h010215);
      // T4: slow peer and an ignored command pulse while busy
      run_txn(8'h20, 8'h33, 8'h11, 8'h22, 8'h33, 7, 5, 1'b1);
      chk("t4_data", 32'(out_resp_data), 32'h332211);
      // cmd 02 is the smallest command code that expects three bytes
      run_txn(8'h02, 8'hC3, 8'hDE, 8'hAD, 8'hBE, 1, 1, 1'b0);
      chk("cmd02_len", 32'(out_resp_len), 32'd3);

      // T5: reset while the request is up
      rv0 = rv_pulses;
      @(posedge in_clk);
      #1 in_cmd = 8'h10;
      in_cmd_valid = 1'b1;
      @(posedge in_clk);
      #1 in_cmd_valid = 1'b0;
      in_peer_rx_enable = 1'b1;
      wait_for(0, 1'b1, "t5_req");
      #2 in_rst_n = 1'b0;
      #1;
      chk("t5_req_async", 32'(out_link_tx_hsk_req), 32'd0);
      chk("t5_busy_async", 32'(out_busy), 32'd0);
      in_peer_rx_enable = 1'b0;
      repeat (2) @(negedge in_clk);
      in_rst_n = 1'b1;
      chk("t5_no_rv", 32'(rv_pulses - rv0), 32'd0);
      chk("t5_idle", 32'({out_busy, out_resp_len}), 32'd0);
      run_txn(8'h01, 8'h7E, 8'h3C, 8'h00, 8'h00, 0, 0, 1'b0);
      chk("t5_after", 32'(out_resp_data), 32'h00003C);

`ifdef PROTO_HOST_TIMEOUT_EN
      // T6: peer never acks
      exp_err  = 1'b1;
      exp_len  = 2'd0;
      exp_data = 24'h0;
      rv0 = rv_pulses;
      in_peer_rx_enable = 1'b1;
      @(posedge in_clk);
      #1 in_cmd = 8'h10;
      in_cmd_valid = 1'b1;
      @(posedge in_clk);
      #1 in_cmd_valid = 1'b0;
      wait_for(0, 1'b1, "t6_req");
      for (int k = 1; k <= 16; k++) begin
         @(negedge in_clk);
         if (k < 16) begin
            chk("t6_no_rv_early", 32'(out_resp_valid), 32'd0);
         end else begin
            chk("t6_rv", 32'(out_resp_valid), 32'd1);
            chk("t6_err", 32'(out_error), 32'd1);
            chk("t6_req_low", 32'(out_link_tx_hsk_req), 32'd0);
            chk("t6_busy_low", 32'(out_busy), 32'd0);
         end
      end
      in_peer_rx_enable = 1'b0;
      repeat (3) @(negedge in_clk);
      chk("t6_rv_count", 32'(rv_pulses - rv0), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
